// File: rtl/program_loader.sv
// Boot-time program loader: receives a length-prefixed little-endian byte stream
// and writes it word by word into instruction memory while holding the core in reset.
module program_loader #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_hold
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic [1:0]            byte_cnt_reg;
    logic [ADDR_WIDTH:0]   index_reg;
    logic [ADDR_WIDTH:0]   len_reg;
    logic [31:0]           asm_reg;

    logic                  rx_fire;
    logic                  last_byte;
    logic [31:0]           asm_shift;
    logic                  len_too_long;
    logic [ADDR_WIDTH:0]   index_inc;
    logic                  can_start;

    // Little-endian assembly: each new byte enters at the top, so after four
    // bytes the first one has reached bits [7:0].
    assign asm_shift    = {rx_data, asm_reg[31:8]};
    assign rx_fire      = rx_valid && rx_ready;
    assign last_byte    = (byte_cnt_reg == 2'd3);
    assign len_too_long = ({1'b0, asm_shift} > (33'd1 << ADDR_WIDTH));
    assign index_inc    = index_reg + 1'b1;
    assign can_start    = (state_reg == ST_IDLE) || (state_reg == ST_DONE) ||
                          (state_reg == ST_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_fire && last_byte) begin
                    if (len_too_long) begin
                        state_next = ST_ERR;
                    end else if (asm_shift == 32'd0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_fire && last_byte) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_next = (index_inc == len_reg) ? ST_DONE : ST_DATA;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: byte counter wraps naturally every four bytes, and the
    // assembly register is shared between the length field and payload words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_reg <= 2'd0;
            index_reg    <= '0;
            len_reg      <= '0;
            asm_reg      <= 32'd0;
        end else begin
            if (can_start && start) begin
                byte_cnt_reg <= 2'd0;
                index_reg    <= '0;
                len_reg      <= '0;
                asm_reg      <= 32'd0;
            end else if (rx_fire) begin
                asm_reg      <= asm_shift;
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
                if (state_reg == ST_LEN && last_byte) begin
                    len_reg <= asm_shift[ADDR_WIDTH:0];
                end
            end else if (state_reg == ST_WRITE) begin
                index_reg <= index_inc;
            end
        end
    end

    always_comb begin
        rx_ready  = (state_reg == ST_LEN) || (state_reg == ST_DATA);
        mem_we    = (state_reg == ST_WRITE);
        mem_addr  = BASE_ADDR + (32'(index_reg) << 2);
        mem_wdata = asm_reg;
        busy      = (state_reg == ST_LEN) || (state_reg == ST_DATA) ||
                    (state_reg == ST_WRITE);
        done      = (state_reg == ST_DONE);
        err       = (state_reg == ST_ERR);
        cpu_hold  = (state_reg != ST_DONE);
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized
// loads with random rx_valid gaps, checked against an expected-write queue.
module tb_program_loader;

    localparam int          AW   = 12;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_hold;

    int vectors;
    int miscompares;
    logic [63:0] exp_q[$];

    program_loader #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_hold  (cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Advance to the next falling edge and audit any write strobe seen there.
    task automatic tick();
        logic [63:0] e;
        @(negedge clk);
        if (mem_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {31'd0, mem_we}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("write addr=%h data=%h", mem_addr, mem_wdata);
                check("write_addr", mem_addr, e[63:32]);
                check("write_data", mem_wdata, e[31:0]);
                check("ready_in_write", {31'd0, rx_ready}, 32'd0);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap, input bit pulse);
        int gap;
        bit fired;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        rx_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            rx_data = 8'($urandom);
            tick();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        start    = pulse;
        fired    = 1'b0;
        for (int i = 0; i < 16 && !fired; i++) begin
            fired = rx_ready;
            tick();
            start = 1'b0;
        end
        rx_valid = 1'b0;
        if (!fired) begin
            vectors++;
            miscompares++;
            $error("FAIL rx_accept observed=timeout expected=accept");
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap, input bit pulse);
        send_byte(w[7:0],   max_gap, pulse);
        send_byte(w[15:8],  max_gap, 1'b0);
        send_byte(w[23:16], max_gap, 1'b0);
        send_byte(w[31:24], max_gap, 1'b0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_clears", {30'd0, done, err}, 32'd0);
    endtask

    // Full load of n words; expected writes come straight from the word list.
    task automatic load(input logic [31:0] n, input int max_gap, input int pulse_idx,
                        input logic [31:0] w0, input logic [31:0] w1);
        logic [31:0] words[$];
        do_start();
        if (n > (32'd1 << AW)) begin
            send_word(n, max_gap, 1'b0);
            check("err_flag", {31'd0, err}, 32'd1);
            check("err_done", {31'd0, done}, 32'd0);
            check("err_hold", {31'd0, cpu_hold}, 32'd1);
            check("err_busy", {31'd0, busy}, 32'd0);
            return;
        end
        for (int i = 0; i < int'(n); i++) begin
            if (i == 0 && w0 != 32'd0)      words.push_back(w0);
            else if (i == 1 && w1 != 32'd0) words.push_back(w1);
            else                            words.push_back($urandom);
            exp_q.push_back({BASE + 32'(4 * i), words[i]});
        end
        send_word(n, max_gap, 1'b0);
        for (int i = 0; i < int'(n); i++) begin
            send_word(words[i], max_gap, i == pulse_idx);
        end
        if (n != 32'd0) begin
            check("we_latency", {31'd0, mem_we}, 32'd1);
            tick();
        end
        check("done_flag", {31'd0, done}, 32'd1);
        check("done_hold", {31'd0, cpu_hold}, 32'd0);
        check("done_err", {31'd0, err}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("writes_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, rx_ready}, 32'd0);
        check({tag, "_we"},    {31'd0, mem_we},   32'd0);
        check({tag, "_flags"}, {29'd0, busy, done, err}, 32'd0);
        check({tag, "_hold"},  {31'd0, cpu_hold}, 32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Two-word directed load with back-to-back bytes.
        load(32'd2, 0, -1, 32'h1234_5678, 32'hDEAD_BEEF);

        // Empty program.
        load(32'd0, 0, -1, 32'd0, 32'd0);

        // One word too many is rejected; exactly full capacity is accepted.
        load(32'd4097, 1, -1, 32'd0, 32'd0);
        do_start();
        send_word(32'd4096, 1, 1'b0);
        check("max_len_busy", {31'd0, busy}, 32'd1);
        check("max_len_err", {31'd0, err}, 32'd0);
        check("max_len_ready", {31'd0, rx_ready}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_max");
        tick();
        rst_n = 1'b1;

        // Random rx_valid gaps, N=3.
        load(32'd3, 3, -1, 32'd0, 32'd0);

        // Reset asserted between clock edges after two payload bytes.
        do_start();
        send_word(32'd2, 1, 1'b0);
        send_byte(8'hAA, 1, 1'b0);
        send_byte(8'hBB, 1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs("post_reset");
        load(32'd3, 2, -1, 32'd0, 32'd0);

        // Start pulsed in the middle of a load must be ignored.
        load(32'd4, 2, 1, 32'd0, 32'd0);
        load(32'd3, 0, 2, 32'd0, 32'd0);

        // Randomized loads.
        for (int r = 0; r < 6; r++) begin
            load(32'($urandom_range(1, 8)), 3, -1, 32'd0, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
